// File: rtl/timer_pkg.sv
// ============================================================================
//  timer_pkg : shared types and width/arithmetic helpers for countdown_timer_ch
//  Rev 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    // Wide enough to hold sum_count*time_score without truncation.
    function automatic int sub_width(input int width, input int time_score);
        return width + $clog2(time_score + 1);
    endfunction

    function automatic int pre_width(input int tick_div);
        return (tick_div > 1) ? $clog2(tick_div) : 1;
    endfunction

    function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
//  timer_prescaler : divides clk_src into one sub-tick every TICK_DIV advances
//  Rev 1.0
// ============================================================================
`default_nettype none

module timer_prescaler
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk_src,
    input  logic rst_n,
    input  logic clr,
    input  logic advance,
    output logic tick
);

    localparam int            PW   = pre_width(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] phase;

    // Phase only moves while advancing, so a pause holds it exactly where it was.
    assign tick = advance && (phase == LAST);

    always_ff @(posedge clk_src) begin
        if (!rst_n || clr) begin
            phase <= '0;
        end else if (tick) begin
            phase <= '0;
        end else if (advance) begin
            phase <= phase + PW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/countdown_timer_ch.sv
// ============================================================================
//  countdown_timer_ch : loadable countdown with prescaler, pause and periodic mode
//  Optional macro TIMER_WARN_EN enables the near-expiry warn_flag comparator.
//  Rev 1.0
// ============================================================================
`default_nettype none

module countdown_timer_ch
    import timer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TICK_DIV    = 25000000,
    parameter int TIME_SCORE  = 2,
    parameter int WARN_THRESH = 3
) (
    input  logic             clk_src,
    input  logic             rst_n,
    input  logic             switch_power,
    input  logic             switch_en,
    input  logic             count_start_flag,
    input  logic             periodic,
    input  logic [WIDTH-1:0] sum_count,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             count_end_flag,
    output logic             end_pulse,
    output logic             warn_flag
);

    localparam int SUBW = sub_width(WIDTH, TIME_SCORE);

    if (TICK_DIV < 1 || TIME_SCORE < 1 || WARN_THRESH < 0) begin : g_param_check
        $error("countdown_timer_ch: illegal parameter set");
    end

    timer_state_t    state, state_nx;
    logic [SUBW-1:0] sub_rem, sub_rem_nx;
    logic [SUBW-1:0] load_val;
    logic            end_flag_nx;
    logic            end_pulse_nx;
    logic            advance;
    logic            pre_clr;
    logic            tick;
    logic            expiry;

    assign load_val = SUBW'(sum_count) * SUBW'(TIME_SCORE);
    assign busy     = (state == RUN) || (state == PAUSE);
    assign paused   = (state == PAUSE);
    assign advance  = busy && switch_en;
    assign pre_clr  = !switch_power || count_start_flag;
    assign expiry   = tick && (sub_rem == SUBW'(1));
    assign count    = WIDTH'(ceil_div(32'(sub_rem), 32'(TIME_SCORE)));

    timer_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_src  (clk_src),
        .rst_n    (rst_n),
        .clr      (pre_clr),
        .advance  (advance),
        .tick     (tick)
    );

    always_ff @(posedge clk_src) begin
        if (!rst_n) begin
            state          <= IDLE;
            sub_rem        <= '0;
            count_end_flag <= 1'b0;
            end_pulse      <= 1'b0;
        end else begin
            state          <= state_nx;
            sub_rem        <= sub_rem_nx;
            count_end_flag <= end_flag_nx;
            end_pulse      <= end_pulse_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        sub_rem_nx   = sub_rem;
        end_flag_nx  = count_end_flag;
        end_pulse_nx = 1'b0;
        if (!switch_power) begin
            state_nx    = IDLE;
            sub_rem_nx  = '0;
            end_flag_nx = 1'b0;
        end else if (count_start_flag) begin
            // Start beats a coincident expiry: reload silently.
            sub_rem_nx = load_val;
            if (load_val == '0) begin
                state_nx     = DONE;
                end_flag_nx  = 1'b1;
                end_pulse_nx = 1'b1;
            end else begin
                state_nx    = switch_en ? RUN : PAUSE;
                end_flag_nx = 1'b0;
            end
        end else if (expiry) begin
            end_pulse_nx = 1'b1;
            if (periodic && (load_val != '0)) begin
                sub_rem_nx = load_val;
                state_nx   = RUN;
            end else begin
                sub_rem_nx  = '0;
                state_nx    = DONE;
                end_flag_nx = 1'b1;
            end
        end else if (busy) begin
            if (tick) begin
                sub_rem_nx = sub_rem - SUBW'(1);
            end
            state_nx = switch_en ? RUN : PAUSE;
        end
    end

`ifdef TIMER_WARN_EN
    logic [WIDTH-1:0] count_nx;
    logic             warn_nx;
    logic             warn_q;

    assign count_nx = WIDTH'(ceil_div(32'(sub_rem_nx), 32'(TIME_SCORE)));
    assign warn_nx  = ((state_nx == RUN) || (state_nx == PAUSE)) &&
                      (count_nx != '0) && (int'(count_nx) <= WARN_THRESH);

    always_ff @(posedge clk_src) begin
        if (!rst_n) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_nx;
        end
    end

    assign warn_flag = warn_q;
`else
    assign warn_flag = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_ch.sv
// ============================================================================
//  tb_countdown_timer_ch : vector table, directed corner sequences and random
//  stimulus against a cycles-remaining reference model.
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_countdown_timer_ch;

    localparam int WIDTH       = 8;
    localparam int TICK_DIV    = 4;
    localparam int TIME_SCORE  = 2;
    localparam int WARN_THRESH = 1;
    localparam int UNIT_CYC    = TICK_DIV * TIME_SCORE;
`ifdef TIMER_WARN_EN
    localparam bit WARN_ON = 1'b1;
`else
    localparam bit WARN_ON = 1'b0;
`endif

    logic             clk_src = 1'b0;
    logic             rst_n, switch_power, switch_en, count_start_flag, periodic;
    logic [WIDTH-1:0] sum_count;
    logic [WIDTH-1:0] count;
    logic             busy, paused, count_end_flag, end_pulse, warn_flag;

    always #5 clk_src = ~clk_src;

    countdown_timer_ch #(
        .WIDTH       (WIDTH),
        .TICK_DIV    (TICK_DIV),
        .TIME_SCORE  (TIME_SCORE),
        .WARN_THRESH (WARN_THRESH)
    ) dut (
        .clk_src          (clk_src),
        .rst_n            (rst_n),
        .switch_power     (switch_power),
        .switch_en        (switch_en),
        .count_start_flag (count_start_flag),
        .periodic         (periodic),
        .sum_count        (sum_count),
        .count            (count),
        .busy             (busy),
        .paused           (paused),
        .count_end_flag   (count_end_flag),
        .end_pulse        (end_pulse),
        .warn_flag        (warn_flag)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: remaining run-cycles until expiry; display value derived by division.
    int m_left   = 0;
    bit m_active = 0;
    bit m_pause  = 0;
    bit m_done   = 0;
    bit m_pulse  = 0;

    function automatic int m_count();
        return (m_left + UNIT_CYC - 1) / UNIT_CYC;
    endfunction

    function automatic int m_warn();
        int c;
        c = m_count();
        return (WARN_ON && m_active && c >= 1 && c <= WARN_THRESH) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        m_pulse = 0;
        if (!rst_n || !switch_power) begin
            m_active = 0; m_pause = 0; m_done = 0; m_left = 0;
        end else if (count_start_flag) begin
            m_left = int'(sum_count) * UNIT_CYC;
            if (m_left == 0) begin
                m_active = 0; m_pause = 0; m_done = 1; m_pulse = 1;
            end else begin
                m_active = 1; m_pause = !switch_en; m_done = 0;
            end
        end else if (m_active) begin
            if (switch_en) begin
                m_pause = 0;
                m_left--;
                if (m_left == 0) begin
                    m_pulse = 1;
                    if (periodic && sum_count != 0) begin
                        m_left = int'(sum_count) * UNIT_CYC;
                    end else begin
                        m_active = 0; m_done = 1;
                    end
                end
            end else begin
                m_pause = 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit p, input bit e, input bit s,
                        input bit per, input int sum);
        rst_n = r; switch_power = p; switch_en = e;
        count_start_flag = s; periodic = per; sum_count = WIDTH'(sum);
        @(posedge clk_src);
        model_edge();
        #1;
        check("model_count", int'(count), m_count());
        check("model_busy", int'(busy), int'(m_active));
        check("model_paused", int'(paused), int'(m_pause));
        check("model_end_flag", int'(count_end_flag), int'(m_done));
        check("model_end_pulse", int'(end_pulse), int'(m_pulse));
        check("model_warn", int'(warn_flag), m_warn());
    endtask

    typedef struct {
        bit r, p, e, s, per;
        int sum;
        int cnt;
        bit bsy, pau, endf, pls;
    } vec_t;

    vec_t tbl[20];
    int   first;
    int   pulses[$];
    int   flag_seen;
    int   exp_cnt[6];

    initial begin
        rst_n = 0; switch_power = 1; switch_en = 1;
        count_start_flag = 0; periodic = 0; sum_count = '0;

        //          r  p  e  s  per sum cnt bsy pau end pls
        tbl[0]  = '{0, 1, 1, 0, 0,  0,  0,  0,  0,  0,  0};
        tbl[1]  = '{1, 1, 1, 0, 0,  0,  0,  0,  0,  0,  0};
        tbl[2]  = '{1, 1, 1, 1, 0,  0,  0,  0,  0,  1,  1};
        tbl[3]  = '{1, 1, 1, 0, 0,  0,  0,  0,  0,  1,  0};
        tbl[4]  = '{1, 1, 1, 1, 0,  3,  3,  1,  0,  0,  0};
        tbl[5]  = '{1, 1, 0, 0, 0,  3,  3,  1,  1,  0,  0};
        tbl[6]  = '{1, 1, 1, 0, 0,  3,  3,  1,  0,  0,  0};
        tbl[7]  = '{1, 0, 1, 0, 0,  3,  0,  0,  0,  0,  0};
        tbl[8]  = '{1, 1, 0, 1, 0,  1,  1,  1,  1,  0,  0};
        tbl[9]  = '{0, 1, 1, 1, 0,  1,  0,  0,  0,  0,  0};
        tbl[10] = '{1, 1, 1, 1, 0,  1,  1,  1,  0,  0,  0};
        for (int i = 11; i <= 17; i++)
            tbl[i] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
        tbl[18] = '{1, 1, 1, 0, 0,  1,  0,  0,  0,  1,  1};
        tbl[19] = '{1, 1, 1, 0, 0,  1,  0,  0,  0,  1,  0};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].p, tbl[i].e, tbl[i].s, tbl[i].per, tbl[i].sum);
            check("tbl_count", int'(count), tbl[i].cnt);
            check("tbl_busy", int'(busy), int'(tbl[i].bsy));
            check("tbl_paused", int'(paused), int'(tbl[i].pau));
            check("tbl_end_flag", int'(count_end_flag), int'(tbl[i].endf));
            check("tbl_end_pulse", int'(end_pulse), int'(tbl[i].pls));
        end

        // One-shot: count steps 3,2,2,1,1,0 every 4 cycles, pulse at 24.
        exp_cnt = '{3, 2, 2, 1, 1, 0};
        step(1, 1, 1, 1, 0, 3);
        first = -1;
        for (int k = 1; k <= 30; k++) begin
            step(1, 1, 1, 0, 0, 3);
            if (end_pulse && first < 0) first = k;
            if (k % 4 == 0 && k <= 24) check("oneshot_count", int'(count), exp_cnt[k/4 - 1]);
            if (k == 15) check("warn_before", int'(warn_flag), 0);
            if (k == 16) check("warn_rise", int'(warn_flag), int'(WARN_ON));
            if (k == 24) check("warn_fall", int'(warn_flag), 0);
        end
        check("oneshot_pulse_cycle", first, 24);
        check("oneshot_end_hold", int'(count_end_flag), 1);

        // Pause 10 cycles starting at cycle 9: pulse slips to 34.
        step(1, 1, 1, 1, 0, 3);
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            step(1, 1, !(k >= 9 && k <= 18), 0, 0, 3);
            if (end_pulse && first < 0) first = k;
            if (k == 12) begin
                check("pause_paused", int'(paused), 1);
                check("pause_count_frozen", int'(count), 2);
            end
        end
        check("pause_pulse_cycle", first, 34);

        // Periodic: period 16, sum lowered to 1 mid-period -> following period 8.
        step(1, 1, 1, 1, 1, 2);
        pulses = {};
        flag_seen = 0;
        for (int k = 1; k <= 45; k++) begin
            step(1, 1, 1, 0, 1, (k >= 20) ? 1 : 2);
            if (end_pulse) pulses.push_back(k);
            if (count_end_flag) flag_seen = 1;
        end
        check("periodic_n_pulses", pulses.size(), 3);
        if (pulses.size() >= 3) begin
            check("periodic_p0", pulses[0], 16);
            check("periodic_p1", pulses[1], 32);
            check("periodic_p2", pulses[2], 40);
        end
        check("periodic_no_end_flag", flag_seen, 0);

        // Clear via power, then via reset, at cycle 10 of a run.
        for (int pass = 0; pass < 2; pass++) begin
            step(1, 1, 1, 1, 0, 3);
            for (int k = 1; k <= 9; k++) step(1, 1, 1, 0, 0, 3);
            step(pass == 1 ? 0 : 1, pass == 0 ? 0 : 1, 1, 0, 0, 3);
            check("clear_busy", int'(busy), 0);
            check("clear_count", int'(count), 0);
            first = -1;
            for (int k = 11; k <= 40; k++) begin
                step(1, 1, 1, 0, 0, 3);
                if (end_pulse && first < 0) first = k;
            end
            check("clear_no_pulse", first, -1);
        end

        // Start coincident with expiry: reload to 5, no pulse, next pulse 40 later.
        step(1, 1, 1, 1, 0, 1);
        for (int k = 1; k <= 7; k++) step(1, 1, 1, 0, 0, 1);
        step(1, 1, 1, 1, 0, 5);
        check("restart_no_pulse", int'(end_pulse), 0);
        check("restart_count", int'(count), 5);
        check("restart_busy", int'(busy), 1);
        first = -1;
        for (int k = 1; k <= 45; k++) begin
            step(1, 1, 1, 0, 0, 5);
            if (end_pulse && first < 0) first = k;
        end
        check("restart_pulse_cycle", first, 40);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(199, 0) != 0,
                 $urandom_range(149, 0) != 0,
                 $urandom_range(4, 0) != 0,
                 $urandom_range(29, 0) == 0,
                 $urandom_range(1, 0) == 1,
                 ($urandom_range(9, 0) == 0) ? int'($urandom_range(255, 0))
                                             : int'($urandom_range(6, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
